// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: byte-wide UART transmitter with a small input FIFO.
// Bytes are taken over a valid/ready handshake, queued, and sent as 8N1 or
// 8N2 frames (start, 8 data bits LSB first, STOP_BITS stop bits). Every bit
// lasts exactly BAUD_TICKS clock cycles. Back-to-back frames carry no idle gap.
module uart_tx_buffered #(
    parameter int BAUD_TICKS = 921,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  data_in,
    input  logic                        data_valid,
    output logic                        data_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(BAUD_TICKS);
    // The stop counter spans the whole stop time so two stop bits fit in one count.
    localparam int STOP_W = $clog2(STOP_BITS * BAUD_TICKS);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_TICKS - 1);
    localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS * BAUD_TICKS - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Serializer state
    state_t           state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [STOP_W-1:0] stop_cnt_q, stop_cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;

    logic             push;
    logic             pop;
    logic             fifo_empty;

    assign fifo_empty = (count_q == '0);
    // Ready depends only on the count, so a full FIFO refuses a push even
    // when the serializer pops on the same edge.
    assign data_ready = (count_q != DEPTH_C);
    assign push       = data_valid && data_ready;

    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE) || !fifo_empty;
    assign fifo_count = count_q;

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO data array; contents need no reset because the count gates reads
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    // Frame sequencer: next state, line level, counters and pop request
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        stop_cnt_d = stop_cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        pop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d       = 1'b1;
                        stop_cnt_d = '0;
                        state_d    = S_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                baud_d = '0;
                if (stop_cnt_q == STOP_LAST) begin
                    stop_cnt_d = '0;
                    if (!fifo_empty) begin
                        // Chain straight into the next start bit: no idle gap.
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    stop_cnt_d = stop_cnt_q + 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset drops the queue and forces the line high at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= S_IDLE;
            baud_q     <= '0;
            stop_cnt_q <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            stop_cnt_q <= stop_cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Testbench for uart_tx_buffered: frame timing, FIFO back-pressure, two stop
// bits, mid-frame reset and a loopback through a behavioural receiver.
module tb_uart_tx_buffered;

    localparam int B3 = 921;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    // Main instance: BAUD_TICKS=8, one stop bit, depth 4
    logic [7:0] data_in;
    logic       data_valid, data_ready, tx, busy;
    logic [2:0] fifo_count;
    // Two-stop-bit instance
    logic [7:0] di2;
    logic       dv2, rdy2, tx2, busy2;
    logic [2:0] cnt2;
    // Default-baud instance for loopback
    logic [7:0] di3;
    logic       dv3, rdy3, tx3, busy3;
    logic [2:0] cnt3;

    uart_tx_buffered #(.BAUD_TICKS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(rst), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
    );

    uart_tx_buffered #(.BAUD_TICKS(8), .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .reset(rst), .data_in(di2), .data_valid(dv2),
        .data_ready(rdy2), .tx(tx2), .busy(busy2), .fifo_count(cnt2)
    );

    uart_tx_buffered #(.BAUD_TICKS(B3), .STOP_BITS(1), .FIFO_DEPTH(4)) dut3 (
        .clk(clk), .reset(rst), .data_in(di3), .data_valid(dv3),
        .data_ready(rdy3), .tx(tx3), .busy(busy3), .fifo_count(cnt3)
    );

    always #5 clk = ~clk;

    // Free-running cycle counter used to timestamp frame starts
    always @(posedge clk) cyc <= cyc + 1;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [7:0] sb[$];
    logic [7:0] sb3[$];
    int         starts[$];
    logic       mon_en = 1'b0;
    int         rx_cnt = 0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] exp_samples;   // bit k = line level at mid of bit slot k
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Push one byte on the main instance; call just after an edge with ready high
    task automatic push1(input logic [7:0] b, input bit track);
        data_in    = b;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        data_in    = 8'($urandom);
        if (track) sb.push_back(b);
    endtask

    // Frame decoder on the main line, popping the scoreboard for each frame
    initial begin : mon_main
        logic [7:0] d;
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                starts.push_back(cyc);
                repeat (4) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (8) @(negedge clk);
                    d[k] = tx;
                end
                repeat (8) @(negedge clk);
                check("mon_stop_bit", tx, 1);
                check("mon_sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) check("mon_byte", d, sb.pop_front());
            end
        end
    end

    // Behavioural receiver on the default-baud line
    initial begin : rx_model
        logic [7:0] d;
        forever begin
            @(negedge clk);
            if (tx3 === 1'b0) begin
                repeat (B3 / 2) @(negedge clk);
                if (tx3 === 1'b0) begin
                    for (int k = 0; k < 8; k++) begin
                        repeat (B3) @(negedge clk);
                        d[k] = tx3;
                    end
                    repeat (B3) @(negedge clk);
                    check("loop_stop_bit", tx3, 1);
                    rx_cnt++;
                    check("loop_sb_nonempty", sb3.size() > 0, 1);
                    if (sb3.size() > 0) check($sformatf("loop_byte%0d", rx_cnt), d, sb3.pop_front());
                end
            end
        end
    end

    int         bad;
    int         w;
    int         t;
    int         ia;
    int         acc[6];
    logic [7:0] bp_bytes[6];
    logic       s2[181];
    int         fall1, fall2, nfall;
    logic       prev;
    logic       b176, b177;
    logic       exp_lvl;

    initial begin : main
        vecs[0] = '{8'hA5, 10'b1_10100101_0};
        vecs[1] = '{8'h00, 10'b1_00000000_0};
        vecs[2] = '{8'hFF, 10'b1_11111111_0};
        vecs[3] = '{8'h3C, 10'b1_00111100_0};
        vecs[4] = '{8'h81, 10'b1_10000001_0};
        bp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        rst = 1'b1;
        data_in = 8'h00; data_valid = 1'b0;
        di2 = 8'h00; dv2 = 1'b0;
        di3 = 8'h00; dv3 = 1'b0;

        // Reset held three cycles, outputs at reset values throughout
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check($sformatf("rst%0d_tx", i), tx, 1);
            check($sformatf("rst%0d_busy", i), busy, 0);
            check($sformatf("rst%0d_count", i), fifo_count, 0);
            check($sformatf("rst%0d_ready", i), data_ready, 1);
        end
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0 || data_ready !== 1'b1) bad++;
        end
        check("reset_quiet_100", bad, 0);
        mon_en = 1'b1;

        // Table-driven single-byte frames
        for (int v = 0; v < 5; v++) begin
            push1(vecs[v].data, 1'b1);                       // edge N
            check($sformatf("vec%0d_count_after_push", v), fifo_count, 1);
            check($sformatf("vec%0d_busy_rise", v), busy, 1);
            check($sformatf("vec%0d_tx_before_start", v), tx, 1);
            tick(1);                                          // edge N+1
            check($sformatf("vec%0d_tx_fall", v), tx, 0);
            check($sformatf("vec%0d_count_popped", v), fifo_count, 0);
            tick(4);                                          // mid start bit
            for (int k = 0; k < 10; k++) begin
                check($sformatf("vec%0d_sample%0d", v, k), tx, vecs[v].exp_samples[k]);
                if (k < 9) tick(8);
            end
            tick(3);                                          // edge N+80
            check($sformatf("vec%0d_busy_n80", v), busy, 1);
            tick(1);                                          // edge N+81
            check($sformatf("vec%0d_busy_n81", v), busy, 0);
            tick(2);
        end

        // Back-pressure: six bytes with valid held high
        starts.delete();
        ia = 0;
        t  = 0;
        data_in    = bp_bytes[0];
        data_valid = 1'b1;
        while (ia < 6 && t < 400) begin
            if (data_ready) begin
                @(posedge clk); #1;
                acc[ia] = t;
                sb.push_back(bp_bytes[ia]);
                ia++;
                if (ia < 6) data_in = bp_bytes[ia];
            end else begin
                @(posedge clk); #1;
            end
            t++;
            if (t == 5) begin
                check("bp_ready_full", data_ready, 0);
                check("bp_count_full", fifo_count, 4);
            end
        end
        data_valid = 1'b0;
        check("bp_all_accepted", ia, 6);
        for (int i = 0; i < 5; i++) check($sformatf("bp_accept_edge%0d", i), acc[i], i);
        check("bp_accept_edge5", acc[5], 82);
        w = 0;
        while (sb.size() != 0 && w < 1000) begin
            tick(1);
            w++;
        end
        check("bp_scoreboard_drained", sb.size(), 0);
        check("bp_frame_count", starts.size(), 6);
        if (starts.size() >= 6) begin
            for (int j = 0; j < 5; j++) check($sformatf("bp_gap%0d", j), starts[j+1] - starts[j], 80);
        end
        tick(10);

        // Reset during data bit 3 with two bytes still queued
        mon_en = 1'b0;
        push1(8'h00, 1'b0);                                   // edge N
        push1(8'h00, 1'b0);
        push1(8'h00, 1'b0);                                   // edge N+2
        check("mid_count_queued", fifo_count, 2);
        tick(34);                                             // edge N+36, inside bit 3
        check("mid_tx_low_bit3", tx, 0);
        #1 rst = 1'b1;
        #1;
        check("mid_tx_async_high", tx, 1);
        check("mid_count_cleared", fifo_count, 0);
        check("mid_busy_cleared", busy, 0);
        check("mid_ready", data_ready, 1);
        tick(2);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("mid_no_resume", bad, 0);
        mon_en = 1'b1;
        push1(8'h3C, 1'b1);
        w = 0;
        while (sb.size() != 0 && w < 200) begin
            tick(1);
            w++;
        end
        check("mid_new_frame_sent", sb.size(), 0);
        tick(10);

        // Two stop bits: 0x00 then 0xFF
        di2 = 8'h00; dv2 = 1'b1;
        tick(1);                                              // edge N
        di2 = 8'hFF;
        tick(1);                                              // edge N+1
        dv2 = 1'b0;
        s2[0] = 1'b1;
        s2[1] = tx2;
        b176 = 1'b0; b177 = 1'b1;
        for (int j = 2; j <= 180; j++) begin
            tick(1);
            s2[j] = tx2;
            if (j == 176) b176 = busy2;
            if (j == 177) b177 = busy2;
        end
        bad = 0; nfall = 0; fall1 = -1; fall2 = -1; prev = 1'b1;
        for (int j = 1; j <= 180; j++) begin
            exp_lvl = !((j <= 72) || (j >= 89 && j <= 96));
            if (s2[j] !== exp_lvl) bad++;
            if (prev == 1'b1 && s2[j] == 1'b0) begin
                if (nfall == 0) fall1 = j;
                else if (nfall == 1) fall2 = j;
                nfall++;
            end
            prev = s2[j];
        end
        check("s2_waveform_errors", bad, 0);
        check("s2_first_fall", fall1, 1);
        check("s2_frame_spacing", fall2 - fall1, 88);
        check("s2_busy_n176", b176, 1);
        check("s2_busy_n177", b177, 0);

        // Loopback at the default baud
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: di3 = 8'h55;
                1: di3 = 8'h00;
                2: di3 = 8'hFF;
                default: di3 = 8'h3C;
            endcase
            dv3 = 1'b1;
            tick(1);
            sb3.push_back(di3);
        end
        dv3 = 1'b0;
        w = 0;
        while (rx_cnt < 4 && w < 40000) begin
            tick(1);
            w++;
        end
        check("loop_frames_received", rx_cnt, 4);
        check("loop_sb_drained", sb3.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

UART transmitter with a small input FIFO; it is the transmit-side counterpart to the team's UART receiver. It accepts bytes over a valid/ready handshake, queues them, and serializes each one as an 8N1 or 8N2 frame on `tx`. Every bit period is exactly `BAUD_TICKS` clock cycles, so a receiver built with the same `BAUD_TICKS` decodes the line directly. Loopback tests on the bench use this block as the stimulus source.

## Interface
Parameters:
- `BAUD_TICKS`, default 921: clock cycles per bit; legal values are ≥ 2.
- `STOP_BITS`, default 1: number of stop bits; legal values are 1 or 2.
- `FIFO_DEPTH`, default 4: FIFO entries; must be a power of 2 and ≥ 2.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears FSM, counters and FIFO.
- `data_in`  in  8  byte to transmit.
- `data_valid`  in  1  `data_in` is valid.
- `data_ready`  out  1  FIFO can accept a byte; equals (count != FIFO_DEPTH).
- `tx`  out  1  serial line, idle high, registered.
- `busy`  out  1  high when the FSM is not in IDLE or the FIFO is non-empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of bytes queued.

## Operation
- Push: on a rising edge where `data_valid && data_ready`, `data_in` is written at the write pointer and the write pointer increments, wrapping modulo FIFO_DEPTH.
- Pop: performed by the FSM; the read pointer wraps modulo FIFO_DEPTH.
- `fifo_count` arithmetic per edge: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- Full boundary: `data_ready` is combinational from the count, so a push is refused while full even if a pop happens on the same edge.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: `tx`=1 and the baud counter is 0. If the FIFO is non-empty, pop the head byte into the shift register, drive `tx`=0, and go to START.
- START: holds `tx`=0 for BAUD_TICKS cycles, then drives bit 0 and goes to DATA with bit index 0.
- DATA: each bit is held for BAUD_TICKS cycles, LSB first. After bit 7, drive `tx`=1 and go to STOP.
- STOP: holds `tx`=1 for STOP_BITS×BAUD_TICKS cycles. At the end of the stop time:
  - FIFO non-empty: pop, drive `tx`=0, and go to START. There is no idle gap between frames.
  - FIFO empty: go to IDLE.
- Baud counter: counts 0..BAUD_TICKS−1 and wraps to 0 on each bit boundary. Its width is $clog2(BAUD_TICKS); the stop counter is widened as needed to cover two stop bits.
- `data_in` is ignored while `data_valid` is low. Changing `data_in` after it has been accepted has no effect on bytes already queued.
- Reset values: `tx`=1, `busy`=0, `fifo_count`=0, `data_ready`=1, state IDLE, pointers 0.
- Reset mid-frame: `tx` returns high asynchronously and the queued bytes are discarded. No partial frame is resumed after reset is released.

## Timing
- Latency: a byte pushed at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1, and `tx` falls at edge N+1.
- Frame length is exactly (9+STOP_BITS)×BAUD_TICKS cycles, measured from the `tx` falling edge to the next possible start.
- Bit k (k=0..7) occupies cycles [(k+1)·BAUD_TICKS, (k+2)·BAUD_TICKS) relative to the start edge.
- `busy` rises the cycle after the first push. It falls at the edge where STOP finishes with the FIFO empty.
- The FIFO can accept one byte per cycle; a continuous valid stream is never dropped, only stalled.

## Test plan
- Reset: assert `reset` for 3 cycles, then release. Required: `tx`=1, `busy`=0, `fifo_count`=0 and `data_ready`=1 throughout, and no `tx` activity for 100 cycles.
- Single byte, BAUD_TICKS=8: push 0xA5 at edge N. Required: `tx` samples taken at mid-bit (every 8 cycles from N+1) read 0,1,0,1,0,0,1,0,1,1. `busy` drops at N+81.
- Back-pressure, FIFO_DEPTH=4: hold `data_valid` high with 6 distinct bytes.
  - Bytes 1–5 are accepted by edge N+4, after which `data_ready`=0 and `fifo_count`=4.
  - Byte 6 is accepted one edge after the first frame ends.
  - All six frames go out contiguously, in order, with no idle cycles between them.
- STOP_BITS=2, BAUD_TICKS=8: push 0x00 then 0xFF. Required: each frame is 88 cycles long, and the second start bit falls exactly 88 cycles after the first.
- Reset mid-frame: assert `reset` during data bit 3 with 2 bytes queued. Required:
  - `tx`=1 asynchronously and `fifo_count`=0.
  - After release, no frame is sent until a new push.
- Loopback, BAUD_TICKS=921: drive the receiver from `tx` and send 0x55, 0x00, 0xFF, 0x3C. Required: the receiver flags valid four times with data 0x55, 0x00, 0xFF, 0x3C, in that order.
